// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - note codes, note frequencies, detector states and nominal-period helper
package tone_pkg;

  // Note codes share the index order of the note-generator bus
  localparam logic [3:0] NOTE_DO2  = 4'd0;
  localparam logic [3:0] NOTE_DO3  = 4'd1;
  localparam logic [3:0] NOTE_FA2  = 4'd2;
  localparam logic [3:0] NOTE_LA1  = 4'd3;
  localparam logic [3:0] NOTE_LA2  = 4'd4;
  localparam logic [3:0] NOTE_MI2  = 4'd5;
  localparam logic [3:0] NOTE_RE2  = 4'd6;
  localparam logic [3:0] NOTE_REB2 = 4'd7;
  localparam logic [3:0] NOTE_REB3 = 4'd8;
  localparam logic [3:0] NOTE_SIB2 = 4'd9;
  localparam logic [3:0] NOTE_SOL2 = 4'd10;
  localparam logic [3:0] NOTE_MUTE = 4'd11;
  localparam logic [3:0] NOTE_RE1  = 4'd12;
  localparam logic [3:0] NOTE_RE3  = 4'd13;
  localparam logic [3:0] NOTE_UNK  = 4'd15;

  localparam int NUM_ENTRIES = 14;

  // Note frequencies in centihertz
  localparam int unsigned F_LA2_CHZ  = 44000;
  localparam int unsigned F_LA1_CHZ  = 22000;
  localparam int unsigned F_DO2_CHZ  = 26163;
  localparam int unsigned F_DO3_CHZ  = 52325;
  localparam int unsigned F_RE1_CHZ  = 14683;
  localparam int unsigned F_RE2_CHZ  = 29366;
  localparam int unsigned F_RE3_CHZ  = 58733;
  localparam int unsigned F_REB2_CHZ = 27718;
  localparam int unsigned F_REB3_CHZ = 55437;
  localparam int unsigned F_MI2_CHZ  = 32963;
  localparam int unsigned F_FA2_CHZ  = 34923;
  localparam int unsigned F_SOL2_CHZ = 39200;
  localparam int unsigned F_SIB2_CHZ = 46616;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    SCAN,
    UPDATE
  } det_state_e;

  // Frequency of a table entry; MUTE and unused codes have none (0)
  function automatic int unsigned note_chz(input int idx);
    case (idx)
      0:       return F_DO2_CHZ;
      1:       return F_DO3_CHZ;
      2:       return F_FA2_CHZ;
      3:       return F_LA1_CHZ;
      4:       return F_LA2_CHZ;
      5:       return F_MI2_CHZ;
      6:       return F_RE2_CHZ;
      7:       return F_REB2_CHZ;
      8:       return F_REB3_CHZ;
      9:       return F_SIB2_CHZ;
      10:      return F_SOL2_CHZ;
      12:      return F_RE1_CHZ;
      13:      return F_RE3_CHZ;
      default: return 0;
    endcase
  endfunction

  // Nominal period in clk cycles, rounded to nearest; 0 for entries without a frequency
  function automatic int unsigned p_nom(input longint unsigned clk_hz, input int unsigned f_chz);
    longint unsigned num;
    if (f_chz == 0) return 0;
    num = clk_hz * 64'd100 + 64'(f_chz >> 1);
    return 32'(num / 64'(f_chz));
  endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// rtl/tone_edge_sync.sv - input synchronizer, optional deglitch (TONE_DEGLITCH_EN), rising-edge pulse
module tone_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tone_i,
  output logic rise_o
);

  logic sync1_q, sync2_q;
  logic level;
  logic level_prev_q;

  // Two-flop synchronizer for the asynchronous note line
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tone_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef TONE_DEGLITCH_EN
  logic       level_q;
  logic [1:0] agree_q;

  // Level follows the synchronized input only after four consecutive differing samples
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      agree_q <= 2'd0;
    end else if (sync2_q == level_q) begin
      agree_q <= 2'd0;
    end else if (agree_q == 2'd3) begin
      level_q <= sync2_q;
      agree_q <= 2'd0;
    end else begin
      agree_q <= agree_q + 2'd1;
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  // Previous level for rising-edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) level_prev_q <= 1'b0;
    else         level_prev_q <= level;
  end

  assign rise_o = level & ~level_prev_q;

endmodule

// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - period-measuring note classifier with debounced note code (TONE_DEGLITCH_EN adds input deglitch)
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned TOL_SHIFT   = 6,
  parameter int unsigned STABLE_CNT  = 3,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [3:0]       note_code,
  output logic             note_valid,
  output logic [CNT_W-1:0] period_out,
  output logic             locked
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);
  localparam logic [3:0]       STABLE  = 4'(STABLE_CNT);

  logic rise;

  tone_edge_sync u_edge (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tone_i (tone_in),
    .rise_o (rise)
  );

  // Nominal periods are elaboration-time constants, one per code
  logic [CNT_W-1:0] pnom_tbl [16];
  for (genvar k = 0; k < 16; k++) begin : g_tbl
    localparam int unsigned PNOM = p_nom(64'(CLK_HZ), note_chz(k));
    assign pnom_tbl[k] = CNT_W'(PNOM);
  end

  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       scan_cand_q, scan_cand_d;
  logic [3:0]       prev_cand_q, prev_cand_d;
  logic [3:0]       stab_q, stab_d;
  logic [3:0]       note_q, note_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] nom, diff;
  logic             match;
  logic             timeout;

  // Window compare of the latched period against the entry under scan
  always_comb begin
    nom   = pnom_tbl[idx_q];
    diff  = (period_q > nom) ? (period_q - nom) : (nom - period_q);
    match = (idx_q != NOTE_MUTE) && (diff <= (nom >> TOL_SHIFT));
  end

  // A coincident edge wins over the timeout so the first edge after silence is never lost
  assign timeout = (cnt_q == TIMEOUT) && !rise;

  // Next-state: period counter, measure/scan/update sequencing, debounce and publish
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    idx_d       = idx_q;
    scan_cand_d = scan_cand_q;
    prev_cand_d = prev_cand_q;
    stab_d      = stab_q;
    note_d      = note_q;
    valid_d     = 1'b0;

    if (rise)                cnt_d = CNT_W'(1);
    else if (cnt_q != TIMEOUT) cnt_d = cnt_q + 1'b1;

    if (timeout) begin
      state_d = WAIT_FIRST;
      stab_d  = 4'd0;
      note_d  = NOTE_MUTE;
      valid_d = (note_q != NOTE_MUTE);
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          if (rise) state_d = MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period_d    = cnt_q;
            idx_d       = 4'd0;
            scan_cand_d = NOTE_UNK;
            state_d     = SCAN;
          end
        end
        SCAN: begin
          // UNK doubles as "nothing matched yet", giving first-match-wins
          if (match && (scan_cand_q == NOTE_UNK)) scan_cand_d = idx_q;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(NUM_ENTRIES - 1)) state_d = UPDATE;
        end
        UPDATE: begin
          if (scan_cand_q == prev_cand_q) stab_d = (stab_q < STABLE) ? (stab_q + 4'd1) : stab_q;
          else                            stab_d = 4'd1;
          prev_cand_d = scan_cand_q;
          if ((stab_d >= STABLE) && (scan_cand_q != note_q)) begin
            note_d  = scan_cand_q;
            valid_d = 1'b1;
          end
          state_d = MEASURE;
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_FIRST;
      cnt_q       <= '0;
      period_q    <= '0;
      idx_q       <= 4'd0;
      scan_cand_q <= NOTE_UNK;
      prev_cand_q <= NOTE_UNK;
      stab_q      <= 4'd0;
      note_q      <= NOTE_MUTE;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      idx_q       <= idx_d;
      scan_cand_q <= scan_cand_d;
      prev_cand_q <= prev_cand_d;
      stab_q      <= stab_d;
      note_q      <= note_d;
      valid_q     <= valid_d;
    end
  end

  assign note_code  = note_q;
  assign note_valid = valid_q;
  assign period_out = period_q;
  assign locked     = (note_q != NOTE_MUTE) && (note_q != NOTE_UNK);

endmodule

// File: tb/tb_tone_detector.sv
// tb/tb_tone_detector.sv - randomized self-checking bench for tone_detector against a note-rule model
module tb_tone_detector;

  localparam int CLK_HZ      = 100_000;
  localparam int TIMEOUT_CYC = 2000;
  localparam int TOL_SHIFT   = 6;
  localparam int STABLE_CNT  = 3;
  localparam int CNT_W       = 20;
  localparam int CHK_DLY     = 30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tone_in = 1'b0;
  logic [3:0]       note_code;
  logic             note_valid;
  logic [CNT_W-1:0] period_out;
  logic             locked;

  tone_detector #(
    .CLK_HZ      (CLK_HZ),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TOL_SHIFT   (TOL_SHIFT),
    .STABLE_CNT  (STABLE_CNT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tone_in    (tone_in),
    .note_code  (note_code),
    .note_valid (note_valid),
    .period_out (period_out),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int cyc = 0;
  int last_rise = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (note_valid === 1'b1) pulses++;

  // Reference model: note frequencies in Hz, index = note code
  real freq_hz [14] = '{261.63, 523.25, 349.23, 220.00, 440.00, 329.63, 293.66,
                        277.18, 554.37, 466.16, 392.00, 0.0, 146.83, 587.33};

  int exp_note = 11;
  int exp_period = 0;
  int exp_pulses = 0;
  bit started = 1'b0;
  int pend = 0;
  int hist[$];

  function automatic int nom(input int k);
    return $rtoi(real'(CLK_HZ) / freq_hz[k] + 0.5);
  endfunction

  function automatic int classify(input int p);
    for (int k = 0; k < 14; k++) begin
      if (k != 11) begin
        int n = nom(k);
        int d = (p > n) ? p - n : n - p;
        if (d <= (n >> TOL_SHIFT)) return k;
      end
    end
    return 15;
  endfunction

  function automatic void model_measure(input int p);
    int c = classify(p);
    bit same = 1'b1;
    exp_period = p;
    hist.push_back(c);
    if (hist.size() >= STABLE_CNT) begin
      for (int j = 0; j < STABLE_CNT; j++)
        if (hist[hist.size() - 1 - j] != c) same = 1'b0;
      if (same && c != exp_note) begin
        exp_note = c;
        exp_pulses++;
      end
    end
  endfunction

  function automatic void model_timeout();
    if (exp_note != 11) begin
      exp_note = 11;
      exp_pulses++;
    end
    hist.delete();
    started = 1'b0;
  endfunction

  function automatic void model_reset();
    exp_note = 11;
    exp_period = 0;
    hist.delete();
    started = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".note"},   32'(note_code),  exp_note);
    check({tag, ".period"}, 32'(period_out), exp_period);
    check({tag, ".locked"}, 32'(locked),     32'(exp_note != 11 && exp_note != 15));
    check({tag, ".pulses"}, pulses,          exp_pulses);
  endtask

  // One period starting with a rising edge; that edge ends and measures the previous period
  task automatic tone_period(input int p, input string tag);
    tone_in = 1'b1;
    last_rise = cyc;
    if (started) model_measure(pend);
    started = 1'b1;
    pend = p;
    tick(CHK_DLY);
    check_outputs(tag);
    tick(p / 2 - CHK_DLY);
    tone_in = 1'b0;
    tick(p - p / 2);
  endtask

  task automatic play(input int p, input int n, input string tag);
    for (int i = 0; i < n; i++) tone_period(p, tag);
  endtask

  task automatic silence(input string tag);
    tick(TIMEOUT_CYC - 10 - (cyc - last_rise));
    check_outputs({tag, ".before"});
    tick(30);
    model_timeout();
    check_outputs({tag, ".after"});
  endtask

  // Short high pulse so the input is already low when reset lands inside the scan
  task automatic reset_mid_scan();
    tone_in = 1'b1;
    last_rise = cyc;
    tick(5);
    tone_in = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_reset();
    check("rst.note",   32'(note_code),  32'd11);
    check("rst.period", 32'(period_out), 32'd0);
    check("rst.locked", 32'(locked),     32'd0);
    check("rst.valid",  32'(note_valid), 32'd0);
    tick(290);
  endtask

  initial begin
    int tol;
    rst_n = 1'b0;
    tone_in = 1'b0;
    tick(4);
    check("reset.note",   32'(note_code),  32'd11);
    check("reset.valid",  32'(note_valid), 32'd0);
    check("reset.period", 32'(period_out), 32'd0);
    check("reset.locked", 32'(locked),     32'd0);
    rst_n = 1'b1;
    tick(3);

    play(nom(4), 4, "la2");
    check("la2.code", 32'(note_code), 32'd4);
    play(nom(0), 4, "do2");
    play(nom(2), 4, "fa2");
    check("fa2.code", 32'(note_code), 32'd2);

    for (int i = 0; i < 3; i++) begin
      play(nom(4), 1, "alt_la2");
      play(nom(10), 1, "alt_sol2");
    end

    tol = nom(10) >> TOL_SHIFT;
    play(nom(10) + tol,     4, "bnd_hi_in");
    play(nom(10) + tol + 1, 4, "bnd_hi_out");
    play(nom(10) - tol,     4, "bnd_lo_in");
    play(nom(10) - tol - 1, 4, "bnd_lo_out");
    play(333, 4, "off300");
    check("off300.code", 32'(note_code), 32'd15);

    play(nom(4), 4, "la2b");
    silence("timeout");
    check("timeout.code", 32'(note_code), 32'd11);

    play(nom(4), 4, "relock");
    reset_mid_scan();
    play(nom(0), 4, "post_rst");

    for (int s = 0; s < 30; s++) begin
      int p;
      int n = int'($urandom_range(1, 4));
      if ($urandom_range(0, 2) < 2) begin
        int k = int'($urandom_range(0, 12));
        int t;
        if (k >= 11) k++;
        t = nom(k) >> TOL_SHIFT;
        p = nom(k) - t + int'($urandom_range(0, 2 * t));
      end else begin
        p = int'($urandom_range(150, 1500));
      end
      play(p, n, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
